// File: rtl/aes_128_loader_if.sv
// Word-stream in, pipeline-core hookup and result stream out for aes_128_loader.
// The DUT takes the slave modport; the environment drives through master.
interface aes_128_loader_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] aes_state;
    logic [127:0] aes_key;
    logic [127:0] aes_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport slave (
        input  in_valid, in_data, aes_out, out_ready,
        output in_ready, aes_state, aes_key, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, aes_out, out_ready,
        input  in_ready, aes_state, aes_key, out_valid, out_data
    );
endinterface

// File: rtl/aes_128_loader.sv
// Loads 8 x 32-bit words into state/key for a fixed-latency AES core, tags launches and buffers
// results in a credit-protected FIFO. Define AES_LOADER_BLK_CNT_EN to add the blk_count_o port.
module aes_128_loader #(
    parameter int unsigned LATENCY = 20,
    parameter int unsigned DEPTH   = 4
) (
    input logic             clk,
    input logic             rst,
    aes_128_loader_if.slave bus_io
`ifdef AES_LOADER_BLK_CNT_EN
    ,
    output logic [31:0]     blk_count_o
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StLoad, StIssue} state_e;

    state_e             state_q;
    logic [2:0]         beat_q;
    logic               in_ready_q;
    logic [127:0]       aes_state_q;
    logic [127:0]       aes_key_q;
    logic [LATENCY-1:0] vld_sr_q;
    logic [CW-1:0]      credit_q, credit_d;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [127:0]       mem_q [DEPTH];

    logic       xfer, launch, push, pop, empty, full;
    logic [6:0] word_lo;

    assign xfer    = bus_io.in_valid & in_ready_q;
    assign launch  = (state_q == StIssue) && (credit_q != '0);
    // Beat n lands at bits [127-32*(n%4) -: 32], i.e. low index 96-32*(n%4).
    assign word_lo = {~beat_q[1:0], 5'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLoad;
            beat_q      <= 3'd0;
            in_ready_q  <= 1'b1;
            aes_state_q <= '0;
            aes_key_q   <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (xfer) begin
                        if (!beat_q[2]) aes_state_q[word_lo +: 32] <= bus_io.in_data;
                        else            aes_key_q[word_lo +: 32]   <= bus_io.in_data;
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            state_q    <= StIssue;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StIssue: begin
                    if (credit_q != '0) begin
                        state_q    <= StLoad;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StLoad;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Credit counts free FIFO slots minus results still travelling through the core.
    always_comb begin
        credit_d = credit_q;
        if (launch && !pop)      credit_d = credit_q - CW'(1);
        else if (pop && !launch) credit_d = credit_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= CW'(DEPTH);
            vld_sr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            vld_sr_q <= (vld_sr_q << 1) | LATENCY'(launch);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus_io.aes_out;
    end

    assign push  = vld_sr_q[LATENCY-1];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = ~empty & bus_io.out_ready;

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.aes_state = aes_state_q;
    assign bus_io.aes_key   = aes_key_q;
    assign bus_io.out_valid = ~empty;
    assign bus_io.out_data  = mem_q[rd_ptr_q[AW-1:0]];

    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

`ifdef AES_LOADER_BLK_CNT_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      blk_cnt_q <= '0;
        else if (pop) blk_cnt_q <= blk_cnt_q + 32'd1;
    end

    assign blk_count_o = blk_cnt_q;
`endif
endmodule

// File: tb/tb_aes_128_loader.sv
// Self-checking bench for aes_128_loader: a behavioural AES-128 stands in for the pipeline core
// and produces the expected ciphertext of every block pushed into an in-order scoreboard.
module tb_aes_128_loader;
    localparam int unsigned LATENCY = 20;
    localparam int unsigned DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_128_loader_if bus ();
`ifdef AES_LOADER_BLK_CNT_EN
    logic [31:0] blk_count;
`endif

    aes_128_loader #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
`ifdef AES_LOADER_BLK_CNT_EN
        ,
        .blk_count_o(blk_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int pops_since_rst = 0;
    int sent = 0;
    bit rand_rdy = 1'b0;
    logic [127:0] exp_q[$];
    int pop_cyc[$];
    logic [7:0] sbox [256];

    typedef struct {
        logic [255:0] blk;
        logic [127:0] ct;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int j = 1; j < 256; j++) if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] st;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[st[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    b[4*c] = a0; b[4*c+1] = a1; b[4*c+2] = a2; b[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = b[i];
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // Stand-in pipeline core: ciphertext of the state/key seen in cycle t appears in t+LATENCY.
    logic [127:0] core_pipe [LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= aes_enc(bus.aes_state, bus.aes_key);
        for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign bus.aes_out = core_pipe[LATENCY-1];

    // Result monitor: in-order scoreboard plus hold-stability while stalled.
    logic         stall_prev = 1'b0;
    logic [127:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && bus.out_valid) check("out_data stable", bus.out_data, held);
            if (bus.out_valid && exp_q.size() == 0) begin
                check("unexpected out_valid", {127'd0, bus.out_valid}, 128'd0);
            end else if (bus.out_valid && bus.out_ready) begin
                check("out_data", bus.out_data, exp_q.pop_front());
                pop_cyc.push_back(cyc);
                pops++;
                pops_since_rst++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
        end
    end

    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_block(input logic [255:0] blk, input logic [127:0] ct, input int max_gap);
        logic rdy;
        int   guard;
        for (int b = 0; b < 8; b++) begin
            if (max_gap > 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = blk[255-32*b -: 32];
            guard = 0;
            do begin
                rdy = bus.in_ready;
                step();
                guard++;
            end while (!rdy && guard < 500);
            if (!rdy) begin
                check("beat accepted", {127'd0, rdy}, 128'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        exp_q.push_back(ct);
        sent++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
        step();
    endtask

    function automatic logic [255:0] rand_blk();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    initial begin
        int n, base;
        bit saw;
        logic [255:0] blk;
        build_sbox();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset in_ready", {127'd0, bus.in_ready}, 128'd1);
        check("reset out_valid", {127'd0, bus.out_valid}, 128'd0);
        check("reset aes_state", bus.aes_state, 128'd0);
        check("reset aes_key", bus.aes_key, 128'd0);

        tbl[0] = '{256'h00112233445566778899aabbccddeeff_000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tbl[1] = '{256'h3243f6a8885a308d313198a2e0370734_2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        for (int i = 3; i < 8; i++) begin
            tbl[i].blk = rand_blk();
            tbl[i].ct  = aes_enc(tbl[i].blk[255:128], tbl[i].blk[127:0]);
        end

        // Isolated blocks: registered state/key during ISSUE and issue-to-out_valid latency.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_block(tbl[i].blk, tbl[i].ct, (i < 3) ? 0 : 2);
            check("issue in_ready", {127'd0, bus.in_ready}, 128'd0);
            check("issue aes_state", bus.aes_state, tbl[i].blk[255:128]);
            check("issue aes_key", bus.aes_key, tbl[i].blk[127:0]);
            n = 0;
            while (!bus.out_valid && n < 100) begin
                step();
                n++;
            end
            check("latency", 128'(n), 128'(LATENCY + 1));
            drain();
        end

        // Two blocks back-to-back: results nine cycles apart.
        base = pop_cyc.size();
        for (int k = 0; k < 2; k++) begin
            blk = rand_blk();
            send_block(blk, aes_enc(blk[255:128], blk[127:0]), 0);
        end
        drain();
        check("b2b spacing", 128'(pop_cyc[base+1] - pop_cyc[base]), 128'd9);

        // Backpressure: four launches fill the credits, the fifth waits in ISSUE.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            blk = rand_blk();
            send_block(blk, aes_enc(blk[255:128], blk[127:0]), 0);
        end
        repeat (LATENCY + 5) step();
        check("stalled in_ready", {127'd0, bus.in_ready}, 128'd0);
        check("stalled out_valid", {127'd0, bus.out_valid}, 128'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("launch cycle in_ready", {127'd0, bus.in_ready}, 128'd0);
        step();
        check("after launch in_ready", {127'd0, bus.in_ready}, 128'd1);
        repeat (3) step();
        bus.out_ready = 1'b1;
        drain();

        // Reset ten cycles after a launch discards the in-flight block.
        blk = rand_blk();
        send_block(blk, aes_enc(blk[255:128], blk[127:0]), 0);
        repeat (10) step();
        rst = 1'b1;
        exp_q.delete();
        pops_since_rst = 0;
        #1;
        check("async reset aes_state", bus.aes_state, 128'd0);
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < LATENCY + 10; k++) begin
            step();
            if (bus.out_valid) saw = 1'b1;
        end
        check("no stale out_valid", {127'd0, saw}, 128'd0);
        check("post reset in_ready", {127'd0, bus.in_ready}, 128'd1);
        send_block(tbl[1].blk, tbl[1].ct, 0);
        drain();

        // Random traffic with random backpressure.
        sent = 0;
        pops = 0;
        rand_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            blk = rand_blk();
            send_block(blk, aes_enc(blk[255:128], blk[127:0]), 3);
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("random pop count", 128'(pops), 128'(sent));
`ifdef AES_LOADER_BLK_CNT_EN
        check("blk_count", 128'(blk_count), 128'(pops_since_rst));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_128_loader.md
AES_128_LOADER -- requirements
Module: aes_128_loader

Interface
REQ-001 Parameter LATENCY, default 20: cycles from launch to valid result on aes_out.
REQ-002 Parameter DEPTH, default 4, power of two >= 2: result FIFO entries.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  word-stream valid.
REQ-006 in_ready  out  1  word-stream ready.
REQ-007 in_data  in  32  word; words 0-3 = state, words 4-7 = key, MSW first.
REQ-008 aes_state  out  128  state to pipeline core, registered.
REQ-009 aes_key  out  128  key to pipeline core, registered.
REQ-010 aes_out  in  128  ciphertext from pipeline core.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  result ready.
REQ-013 out_data  out  128  ciphertext, FIFO head.

Function
REQ-014 Word transfer occurs when in_valid && in_ready; beat n (0-7) writes bits [127-32*(n%4) -: 32] of aes_state (n<4) or aes_key (n>=4).
REQ-015 FSM states: LOAD and ISSUE. LOAD: in_ready=1; 3-bit beat counter increments per transfer; the transfer of beat 7 moves to ISSUE and clears the counter.
REQ-016 ISSUE: in_ready=0; aes_state/aes_key held; launch=1 when credit>0, then return to LOAD; with credit==0, stay in ISSUE.
REQ-017 Launch pushes a 1 into a LATENCY-bit valid shift register; a non-launch cycle pushes 0.
REQ-018 Launch in cycle t makes the FIFO write aes_out at the edge ending cycle t+LATENCY.
REQ-019 Credit counter (log2(DEPTH)+1 bits) resets to DEPTH, decrements on launch and increments on pop (out_valid && out_ready); simultaneous launch and pop leaves it unchanged.
REQ-020 Credit guarantees FIFO never overflows; a write while full is a design error, flagged by an assertion.
REQ-021 FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit; simultaneous push and pop while full or empty is legal.
REQ-022 out_valid = FIFO not empty; out_data = head entry, stable while out_valid && !out_ready.
REQ-023 Beats may arrive back-to-back; a new block may load while earlier blocks are in flight.
REQ-024 Partial aes_state/aes_key values during LOAD carry no valid tag and never reach the FIFO.

Reset
REQ-025 rst asserted: FSM=LOAD, beat counter=0, aes_state=aes_key=0, shift register=0, credit=DEPTH, FIFO empty, out_valid=0, in_ready=1 after release.
REQ-026 Reset mid-operation discards partially loaded words, in-flight tags and buffered results; no out_valid is produced for them after release.

Configuration
REQ-027 Macro AES_LOADER_BLK_CNT_EN defined: adds output port blk_count (32 bits), reset 0, incremented on each pop, wrapping 0xFFFFFFFF->0.
REQ-028 Macro absent: no blk_count port and no counter logic; all other behaviour is identical.

Verification
REQ-029 Load words 00112233,44556677,8899aabb,ccddeeff,00010203,04050607,08090a0b,0c0d0e0f, out_ready=1 -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly LATENCY+1 cycles after the ISSUE cycle (one cycle FIFO).
REQ-030 Two blocks back-to-back with no idle -> two results 9 cycles apart, in order, none lost.
REQ-031 out_ready=0, DEPTH=4, five blocks -> four launched, FSM holds ISSUE with in_ready=0; one pop -> fifth launches next cycle; five correct results drain in order.
REQ-032 rst pulsed 10 cycles after a launch -> no out_valid for that block; the next block loaded afterwards returns the correct result.
REQ-033 With AES_LOADER_BLK_CNT_EN, three pops -> blk_count=3; preloaded to 0xFFFFFFFF, one pop -> blk_count=0.
